// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared state encoding and default timing constants for button conditioning
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } btn_fsm_t;

  localparam int CLK_HZ      = 12_000_000;
  localparam int DEBOUNCE_MS = 1;
  localparam int LONG_MS     = 1000;

  localparam int DEFAULT_DEBOUNCE_CYCLES = (CLK_HZ / 1000) * DEBOUNCE_MS;
  localparam int DEFAULT_LONG_CYCLES     = (CLK_HZ / 1000) * LONG_MS;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - generic two-flop synchronizer for asynchronous pin inputs
module sync_2ff #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // first flop may go metastable; second flop gives it a full cycle to settle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - debounces a raw push-button into a level plus press/release/long-press strobes
module button_debouncer
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEFAULT_LONG_CYCLES,
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_state,
  output logic press,
  output logic release_pulse,
  output logic long_press
);

  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int HOLD_W = $clog2(LONG_CYCLES + 1);

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);

  logic pin;
  logic s;

  btn_fsm_t          state, next_state;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic [HOLD_W-1:0] hold, hold_next;
  logic              fired, fired_next;

  // polarity is normalised before the synchronizer so everything downstream sees 1 = pressed
  assign pin = ACTIVE_LOW ? ~btn_in : btn_in;

  sync_2ff #(
    .WIDTH      (1),
    .RESET_VALUE(1'b0)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (pin),
    .q  (s)
  );

  // state, debounce counter, hold counter and long-press-fired flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      hold  <= '0;
      fired <= 1'b0;
    end else begin
      state <= next_state;
      cnt   <= cnt_next;
      hold  <= hold_next;
      fired <= fired_next;
    end
  end

  // next-state and strobe decode; a change of s always beats a terminal count
  always_comb begin
    next_state    = state;
    cnt_next      = cnt;
    hold_next     = hold;
    fired_next    = fired;
    btn_state     = 1'b0;
    press         = 1'b0;
    release_pulse = 1'b0;
    long_press    = 1'b0;

    case (state)
      IDLE: begin
        if (s) begin
          next_state = PRESS_WAIT;
          cnt_next   = '0;
        end
      end

      PRESS_WAIT: begin
        if (!s) begin
          next_state = IDLE;
        end else if (cnt == CNT_LAST) begin
          next_state = PRESSED;
          press      = 1'b1;
          hold_next  = '0;
          fired_next = 1'b0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end

      PRESSED: begin
        btn_state = 1'b1;
        if (hold != HOLD_MAX) begin
          hold_next = hold + HOLD_W'(1);
        end
        if (hold == HOLD_LAST && !fired) begin
          long_press = 1'b1;
          fired_next = 1'b1;
        end
        if (!s) begin
          next_state = RELEASE_WAIT;
          cnt_next   = '0;
        end
      end

      RELEASE_WAIT: begin
        btn_state = 1'b1;
        if (s) begin
          next_state = PRESSED;
        end else if (cnt == CNT_LAST) begin
          next_state    = IDLE;
          release_pulse = 1'b1;
          hold_next     = '0;
          fired_next    = 1'b0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end

      default: begin
        next_state = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_button_debouncer.sv
// tb/tb_button_debouncer.sv - randomized and directed checks of button_debouncer against a run-length model
module tb_button_debouncer;

  localparam int D = 4;
  localparam int L = 20;

  logic clk = 1'b0;
  logic rst;
  logic btn_in0, btn_in1;
  logic st0, pr0, rl0, lp0;
  logic st1, pr1, rl1, lp1;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int rst_cyc;

  // model: debounced level, run length of s disagreeing with level, cycles held, fired flag
  int m_a[2], m_b[2], m_level[2], m_run[2], m_hold[2], m_fired[2];
  int m_np[2], m_nr[2], m_nl[2];
  // observed DUT events
  int n_press[2], n_rel[2], n_long[2], pcyc[2], rcyc[2], lcyc[2];

  always #5 clk = ~clk;

  button_debouncer #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .ACTIVE_LOW(1'b0)) dut0 (
    .clk(clk), .rst(rst), .btn_in(btn_in0), .btn_state(st0),
    .press(pr0), .release_pulse(rl0), .long_press(lp0)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .ACTIVE_LOW(1'b1)) dut1 (
    .clk(clk), .rst(rst), .btn_in(btn_in1), .btn_state(st1),
    .press(pr1), .release_pulse(rl1), .long_press(lp1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_a[i] = 0; m_b[i] = 0; m_level[i] = 0; m_run[i] = 0;
      m_hold[i] = 0; m_fired[i] = 0;
    end
  endfunction

  // a new level is accepted on the (D+1)th consecutive cycle that s disagrees with it;
  // long press fires on the L-th steady-pressed cycle, once per press
  function automatic logic [3:0] model_out(int i);
    logic p, r, l;
    p = 1'b0; r = 1'b0; l = 1'b0;
    if (m_b[i] != m_level[i] && m_run[i] + 1 == D + 1) begin
      if (m_level[i] == 0) p = 1'b1;
      else r = 1'b1;
    end
    if (m_level[i] == 1 && m_run[i] == 0 && m_hold[i] + 1 == L && m_fired[i] == 0) l = 1'b1;
    return {m_level[i] == 1, p, r, l};
  endfunction

  function automatic void model_step(int i, int pin);
    logic [3:0] o;
    o = model_out(i);
    if (m_level[i] == 1 && m_run[i] == 0) begin
      if (m_hold[i] < L) m_hold[i]++;
      if (o[0]) begin m_fired[i] = 1; m_nl[i]++; end
    end
    if (o[2] || o[1]) begin
      if (o[2]) m_np[i]++; else m_nr[i]++;
      m_level[i] = 1 - m_level[i];
      m_run[i] = 0; m_hold[i] = 0; m_fired[i] = 0;
    end else if (m_b[i] == m_level[i]) begin
      m_run[i] = 0;
    end else begin
      m_run[i]++;
    end
    m_b[i] = m_a[i];
    m_a[i] = pin;
  endfunction

  task automatic compare(input int i, input logic st, input logic pr, input logic rl, input logic lp);
    logic [3:0] o;
    o = model_out(i);
    check($sformatf("btn_state%0d", i), st, o[3]);
    check($sformatf("press%0d", i), pr, o[2]);
    check($sformatf("release%0d", i), rl, o[1]);
    check($sformatf("long%0d", i), lp, o[0]);
    check($sformatf("excl%0d", i), (32'(pr) + 32'(rl) + 32'(lp)) <= 1, 1);
    if (pr) begin n_press[i]++; pcyc[i] = cyc; end
    if (rl) begin n_rel[i]++;   rcyc[i] = cyc; end
    if (lp) begin n_long[i]++;  lcyc[i] = cyc; end
  endtask

  // v0/v1 are the logical "pressed" values; dut1 gets the inverted pin
  task automatic tick(input logic v0, input logic v1);
    btn_in0 = v0;
    btn_in1 = ~v1;
    @(negedge clk);
    compare(0, st0, pr0, rl0, lp0);
    compare(1, st1, pr1, rl1, lp1);
    @(posedge clk);
    model_step(0, int'(v0));
    model_step(1, int'(v1));
    cyc++;
    #1;
  endtask

  task automatic ticks(input int n, input logic v0, input logic v1);
    for (int k = 0; k < n; k++) tick(v0, v1);
  endtask

  task automatic do_async_reset();
    #3 rst = 1'b1;
    #1;
    check("arst_state0", st0, 0); check("arst_press0", pr0, 0);
    check("arst_rel0", rl0, 0);   check("arst_long0", lp0, 0);
    check("arst_state1", st1, 0); check("arst_press1", pr1, 0);
    check("arst_rel1", rl1, 0);   check("arst_long1", lp1, 0);
    model_reset();
    @(posedge clk);
    cyc++;
    #1 rst = 1'b0;
    rst_cyc = cyc;
  endtask

  initial begin
    int np0, nr0, nl0, v0, v1, len;
    rst = 1'b1;
    btn_in0 = 1'b0;
    btn_in1 = 1'b1;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      m_np[i] = 0; m_nr[i] = 0; m_nl[i] = 0;
      n_press[i] = 0; n_rel[i] = 0; n_long[i] = 0;
      pcyc[i] = -1; rcyc[i] = -1; lcyc[i] = -1;
    end

    @(negedge clk);
    check("reset_state0", st0, 0); check("reset_press0", pr0, 0);
    check("reset_rel0", rl0, 0);   check("reset_long0", lp0, 0);
    check("reset_state1", st1, 0); check("reset_press1", pr1, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // clean press at cycle 10, clean release at cycle 30, both polarities
    while (cyc < 10) tick(0, 0);
    while (cyc < 30) tick(1, 1);
    while (cyc < 45) tick(0, 0);
    check("s1_press_cyc0", pcyc[0], 16);
    check("s1_press_cyc1", pcyc[1], 16);
    check("s3_rel_cyc0", rcyc[0], 36);
    check("s3_rel_cyc1", rcyc[1], 36);
    check("s3_npress0", n_press[0], 1);
    check("s3_nrel0", n_rel[0], 1);
    check("s1_nlong0", n_long[0], 0);

    // bounce rejection: three 3-cycle pulses with 2-cycle gaps
    for (int r = 0; r < 3; r++) begin
      ticks(3, 1, 1);
      ticks(2, 0, 0);
    end
    ticks(10, 0, 0);
    check("s2_npress0", n_press[0], 1);
    check("s2_npress1", n_press[1], 1);

    // long press, then a 2-cycle release glitch after it has fired
    np0 = n_press[0]; nr0 = n_rel[0]; nl0 = n_long[0];
    ticks(46, 1, 1);
    check("s4_long_lat0", lcyc[0] - pcyc[0], 20);
    check("s4_long_lat1", lcyc[1] - pcyc[1], 20);
    ticks(2, 0, 0);
    ticks(10, 1, 1);
    check("s4_glitch_rel0", n_rel[0] - nr0, 0);
    ticks(12, 0, 0);
    check("s4_dpress0", n_press[0] - np0, 1);
    check("s4_drel0", n_rel[0] - nr0, 1);
    check("s4_dlong0", n_long[0] - nl0, 1);
    check("s4_dlong1", n_long[1], 1);

    // async reset during PRESS_WAIT, then during PRESSED, input held pressed
    ticks(4, 1, 1);
    do_async_reset();
    ticks(10, 1, 1);
    check("s5_pw_lat0", pcyc[0] - rst_cyc, 6);
    check("s5_pw_lat1", pcyc[1] - rst_cyc, 6);
    ticks(3, 1, 1);
    do_async_reset();
    ticks(8, 1, 1);
    check("s5_pr_lat0", pcyc[0] - rst_cyc, 6);
    ticks(12, 0, 0);

    // randomized segments of independent random levels and lengths
    for (int seg = 0; seg < 260; seg++) begin
      v0 = int'($urandom_range(0, 1));
      v1 = int'($urandom_range(0, 1));
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 45)) : int'($urandom_range(1, 8));
      ticks(len, v0[0], v1[0]);
      if ($urandom_range(0, 49) == 0) do_async_reset();
    end
    ticks(15, 0, 0);

    for (int i = 0; i < 2; i++) begin
      check($sformatf("total_press%0d", i), n_press[i], m_np[i]);
      check($sformatf("total_rel%0d", i), n_rel[i], m_nr[i]);
      check($sformatf("total_long%0d", i), n_long[i], m_nl[i]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
